// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for a small register-file/ALU
// datapath. It accepts one 16-bit instruction per FETCH handshake, holds it in
// the instruction register (IR) and then sequences EXEC (and WB where needed).
// Datapath controls are decoded combinationally from the state and the IR.
// The datapath bypassb input must be tied low at integration; it is not driven here.
module control_unit #(
    parameter int M = 3,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic         z_flag,
    input  logic         n_flag,
    input  logic         o_flag,
    output logic         ie,
    output logic         write,
    output logic         reada,
    output logic         readb,
    output logic [M-1:0] waddr,
    output logic [M-1:0] ra,
    output logic [M-1:0] rb,
    output logic [2:0]   op,
    output logic         en,
    output logic         oe,
    output logic [N-1:0] offset,
    output logic         bypassa,
    output logic [N-1:0] pc,
    output logic         halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_NOP  = 4'd7;
    localparam logic [3:0] OP_LDI  = 4'd8;
    localparam logic [3:0] OP_IN   = 4'd9;
    localparam logic [3:0] OP_OUT  = 4'd10;
    localparam logic [3:0] OP_BRZ  = 4'd11;
    localparam logic [3:0] OP_BRN  = 4'd12;
    localparam logic [3:0] OP_BRO  = 4'd13;
    localparam logic [3:0] OP_BRA  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0]   ALU_PASS = 3'b110;
    localparam logic [N-1:0] PC_ONE   = {{(N-1){1'b0}}, 1'b1};

    // Register-field index resized to the register-file address width.
    function automatic logic [M-1:0] to_addr(input logic [2:0] field);
        return M'(field);
    endfunction

    // Immediate routed to the ALU: unsigned, resized to the data width.
    function automatic logic [N-1:0] zext_imm(input logic [7:0] v);
        return N'(v);
    endfunction

    // Branch displacement: two's-complement byte sign-extended to the pc width.
    function automatic logic [N-1:0] sext_imm(input logic [7:0] v);
        return N'($signed(v));
    endfunction

    state_t       state_r;
    state_t       next_state_s;
    logic [N-1:0] pc_r;
    logic [N-1:0] pc_next_s;
    logic [15:0]  ir_r;
    logic         ir_load_s;

    logic [3:0]   opcode_s;
    logic [2:0]   r1_s;
    logic [2:0]   r2_s;
    logic [2:0]   r3_s;
    logic [7:0]   imm_s;
    logic [N-1:0] pc_plus1_s;
    logic [N-1:0] pc_branch_s;

    assign opcode_s    = ir_r[15:12];
    assign r1_s        = ir_r[11:9];
    assign r2_s        = ir_r[8:6];
    assign r3_s        = ir_r[5:3];
    assign imm_s       = ir_r[7:0];
    assign pc_plus1_s  = pc_r + PC_ONE;
    assign pc_branch_s = pc_r + sext_imm(imm_s);

    assign pc     = pc_r;
    assign halted = (state_r == S_HALT);

    // State, program counter and instruction register; reset aborts any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            pc_r    <= '0;
            ir_r    <= 16'h0000;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            if (ir_load_s) begin
                ir_r <= instr;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-state, next-pc and datapath control decode; everything idles while rst is high.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        ir_load_s    = 1'b0;
        instr_ready  = 1'b0;
        ie           = 1'b0;
        write        = 1'b0;
        reada        = 1'b0;
        readb        = 1'b0;
        waddr        = '0;
        ra           = '0;
        rb           = '0;
        op           = 3'b000;
        en           = 1'b0;
        oe           = 1'b0;
        offset       = '0;
        bypassa      = 1'b0;

        if (rst) begin
            next_state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        ir_load_s    = 1'b1;
                        next_state_s = S_EXEC;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end

                S_EXEC: begin
                    case (opcode_s)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
                            ra           = to_addr(r2_s);
                            rb           = to_addr(r3_s);
                            reada        = 1'b1;
                            readb        = 1'b1;
                            op           = opcode_s[2:0];
                            en           = 1'b1;
                            next_state_s = S_WB;
                        end
                        OP_LDI: begin
                            bypassa      = 1'b1;
                            offset       = zext_imm(imm_s);
                            op           = ALU_PASS;
                            en           = 1'b1;
                            next_state_s = S_WB;
                        end
                        OP_IN: begin
                            // External data is written straight in; no WB cycle needed.
                            ie           = 1'b1;
                            write        = 1'b1;
                            waddr        = to_addr(r1_s);
                            pc_next_s    = pc_plus1_s;
                            next_state_s = S_FETCH;
                        end
                        OP_OUT: begin
                            ra           = to_addr(r2_s);
                            reada        = 1'b1;
                            op           = ALU_PASS;
                            en           = 1'b1;
                            next_state_s = S_WB;
                        end
                        OP_BRZ: begin
                            if (z_flag) begin
                                pc_next_s = pc_branch_s;
                            end else begin
                                pc_next_s = pc_plus1_s;
                            end
                            next_state_s = S_FETCH;
                        end
                        OP_BRN: begin
                            if (n_flag) begin
                                pc_next_s = pc_branch_s;
                            end else begin
                                pc_next_s = pc_plus1_s;
                            end
                            next_state_s = S_FETCH;
                        end
                        OP_BRO: begin
                            if (o_flag) begin
                                pc_next_s = pc_branch_s;
                            end else begin
                                pc_next_s = pc_plus1_s;
                            end
                            next_state_s = S_FETCH;
                        end
                        OP_BRA: begin
                            pc_next_s    = pc_branch_s;
                            next_state_s = S_FETCH;
                        end
                        OP_NOP: begin
                            pc_next_s    = pc_plus1_s;
                            next_state_s = S_FETCH;
                        end
                        OP_HALT: begin
                            next_state_s = S_HALT;
                        end
                        default: begin
                            pc_next_s    = pc_plus1_s;
                            next_state_s = S_FETCH;
                        end
                    endcase
                end

                S_WB: begin
                    // Only ALU ops, LDI and OUT reach WB.
                    if (opcode_s == OP_OUT) begin
                        oe = 1'b1;
                    end else begin
                        write = 1'b1;
                        waddr = to_addr(r1_s);
                    end
                    pc_next_s    = pc_plus1_s;
                    next_state_s = S_FETCH;
                end

                S_HALT: begin
                    next_state_s = S_HALT;
                end

                default: begin
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit with a small behavioural datapath model
// (register file, ALU result/flag registers) so flags and dout are realistic.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        z_flag, n_flag, o_flag;
    logic        ie, write, reada, readb;
    logic [2:0]  waddr, ra, rb, op;
    logic        en, oe, bypassa, halted;
    logic [7:0]  offset, pc;

    int total  = 0;
    int passed = 0;

    // Datapath model
    logic [7:0] rf [0:7];
    logic [7:0] alu_r;
    logic [7:0] din;
    logic [7:0] a_s, b_s, dout_s;
    logic [8:0] alu_out_s;

    always #5 clk = ~clk;

    control_unit #(.M(3), .N(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .z_flag(z_flag), .n_flag(n_flag), .o_flag(o_flag),
        .ie(ie), .write(write), .reada(reada), .readb(readb), .waddr(waddr),
        .ra(ra), .rb(rb), .op(op), .en(en), .oe(oe), .offset(offset),
        .bypassa(bypassa), .pc(pc), .halted(halted)
    );

    // ALU model: returns {overflow, result}
    function automatic logic [8:0] alu_f(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       v;
        v = 1'b0;
        case (o)
            3'd0: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            default: r = a;
        endcase
        return {v, r};
    endfunction

    assign a_s       = bypassa ? offset : rf[ra];
    assign b_s       = rf[rb];
    assign alu_out_s = alu_f(op, a_s, b_s);
    assign dout_s    = oe ? alu_r : 8'h00;

    always @(posedge clk) begin
        if (write) rf[waddr] <= ie ? din : alu_r;
        if (en) begin
            alu_r  <= alu_out_s[7:0];
            z_flag <= (alu_out_s[7:0] == 8'h00);
            n_flag <= alu_out_s[7];
            o_flag <= alu_out_s[8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 16'h8205; instr_valid = 1'b1;
        step(); step();
        total++; if (instr_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", instr_ready); else passed++;
        total++; if (pc !== 8'd0) $display("FAIL rst_pc: got %0d expected 0", pc); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b expected 0", halted); else passed++;
        total++; if ({write, en, oe, ie, reada, readb, bypassa} !== 7'b0) $display("FAIL rst_ctrl: got %b expected 0", {write, en, oe, ie, reada, readb, bypassa}); else passed++;
        rst = 1'b0; instr_valid = 1'b0;
        #1;
        total++; if (instr_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", instr_ready); else passed++;
    endtask

    task automatic test_ldi_add_out();
        issue(16'h8205); // LDI r1,5
        total++; if ({bypassa, offset, op, en} !== {1'b1, 8'd5, 3'b110, 1'b1}) $display("FAIL ldi_exec: got %b/%0d/%0d/%b expected 1/5/6/1", bypassa, offset, op, en); else passed++;
        step();
        total++; if ({write, waddr, ie} !== {1'b1, 3'd1, 1'b0}) $display("FAIL ldi_wb: got %b/%0d/%b expected 1/1/0", write, waddr, ie); else passed++;
        step();
        total++; if (pc !== 8'd1) $display("FAIL ldi_pc: got %0d expected 1", pc); else passed++;
        issue(16'h8403); step(); step(); // LDI r2,3
        issue(16'h0650); // ADD r3=r1+r2
        total++; if ({ra, rb, reada, readb, op, en} !== {3'd1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b1}) $display("FAIL add_exec: got ra=%0d rb=%0d op=%0d expected ra=1 rb=2 op=0", ra, rb, op); else passed++;
        step();
        total++; if ({write, waddr} !== {1'b1, 3'd3}) $display("FAIL add_wb: got %b/%0d expected 1/3", write, waddr); else passed++;
        step();
        total++; if (pc !== 8'd3) $display("FAIL add_pc: got %0d expected 3", pc); else passed++;
        issue(16'hA0C0); // OUT r3
        total++; if ({ra, reada, readb, op, en, oe} !== {3'd3, 1'b1, 1'b0, 3'b110, 1'b1, 1'b0}) $display("FAIL out_exec: got ra=%0d op=%0d oe=%b expected ra=3 op=6 oe=0", ra, op, oe); else passed++;
        step();
        total++; if ({oe, write} !== 2'b10) $display("FAIL out_wb_oe: got oe=%b write=%b expected oe=1 write=0", oe, write); else passed++;
        total++; if (dout_s !== 8'd8) $display("FAIL out_dout: got %0d expected 8", dout_s); else passed++;
        step();
        total++; if (oe !== 1'b0) $display("FAIL out_oe_pulse: got %b expected 0", oe); else passed++;
        total++; if (pc !== 8'd4) $display("FAIL out_pc: got %0d expected 4", pc); else passed++;
    endtask

    task automatic test_idle();
        instr = 16'h0650; instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({instr_ready, pc, write, en, oe, reada, readb, ie, bypassa} !== {1'b1, 8'd4, 7'b0})
                $display("FAIL idle_%0d: got ready=%b pc=%0d ctrl=%b expected ready=1 pc=4 ctrl=0", i, instr_ready, pc, {write, en, oe, reada, readb, ie, bypassa});
            else passed++;
        end
    endtask

    task automatic test_branch();
        rst = 1'b1; step(); rst = 1'b0;
        issue(16'h1248); // SUB r1=r1-r1
        total++; if ({op, ra, rb} !== {3'd1, 3'd1, 3'd1}) $display("FAIL sub_exec: got op=%0d ra=%0d rb=%0d expected 1/1/1", op, ra, rb); else passed++;
        step(); step();
        total++; if (pc !== 8'd1) $display("FAIL sub_pc: got %0d expected 1", pc); else passed++;
        issue(16'hB0FE); // BRZ -2
        total++; if ({en, write} !== 2'b00) $display("FAIL brz_exec: got en=%b write=%b expected 0/0", en, write); else passed++;
        step();
        total++; if (pc !== 8'd255) $display("FAIL brz_taken_pc: got %0d expected 255", pc); else passed++;
        total++; if (instr_ready !== 1'b1) $display("FAIL brz_fetch: got %b expected 1", instr_ready); else passed++;
        issue(16'hC010); step(); // BRN not taken, wraps
        total++; if (pc !== 8'd0) $display("FAIL brn_wrap_pc: got %0d expected 0", pc); else passed++;
        issue(16'hE005); step(); // BRA +5
        total++; if (pc !== 8'd5) $display("FAIL bra_pc: got %0d expected 5", pc); else passed++;
        issue(16'hD040); step(); // BRO not taken
        total++; if (pc !== 8'd6) $display("FAIL bro_pc: got %0d expected 6", pc); else passed++;
    endtask

    task automatic test_in_nop();
        din = 8'hA5;
        issue(16'h9800); // IN r4
        total++; if ({write, ie, waddr, en} !== {1'b1, 1'b1, 3'd4, 1'b0}) $display("FAIL in_exec: got write=%b ie=%b waddr=%0d en=%b expected 1/1/4/0", write, ie, waddr, en); else passed++;
        step();
        total++; if ({instr_ready, pc} !== {1'b1, 8'd7}) $display("FAIL in_done: got ready=%b pc=%0d expected 1/7", instr_ready, pc); else passed++;
        total++; if (rf[4] !== 8'hA5) $display("FAIL in_data: got %h expected a5", rf[4]); else passed++;
        issue(16'h7000); // NOP
        total++; if ({write, en, oe, reada, readb, ie, bypassa} !== 7'b0) $display("FAIL nop_exec: got %b expected 0", {write, en, oe, reada, readb, ie, bypassa}); else passed++;
        step();
        total++; if (pc !== 8'd8) $display("FAIL nop_pc: got %0d expected 8", pc); else passed++;
    endtask

    task automatic test_back_to_back();
        issue(16'h0A90); // ADD r5=r2+r2
        instr = 16'h0E00; instr_valid = 1'b1; // must be ignored outside FETCH
        total++; if (instr_ready !== 1'b0) $display("FAIL b2b_ready_exec: got %b expected 0", instr_ready); else passed++;
        step();
        total++; if ({write, waddr} !== {1'b1, 3'd5}) $display("FAIL b2b_wb: got %b/%0d expected 1/5", write, waddr); else passed++;
        step();
        total++; if ({rf[5], pc} !== {8'd6, 8'd9}) $display("FAIL b2b_result: got r5=%0d pc=%0d expected 6/9", rf[5], pc); else passed++;
        step(); // handshake on held valid
        instr_valid = 1'b0;
        total++; if ({ra, rb, reada, en} !== {3'd0, 3'd0, 1'b1, 1'b1}) $display("FAIL b2b_second_exec: got ra=%0d rb=%0d reada=%b en=%b expected 0/0/1/1", ra, rb, reada, en); else passed++;
        step();
        total++; if (waddr !== 3'd7) $display("FAIL b2b_second_wb: got %0d expected 7", waddr); else passed++;
        step();
        total++; if (pc !== 8'd10) $display("FAIL b2b_pc: got %0d expected 10", pc); else passed++;
    endtask

    task automatic test_halt();
        issue(16'hF000);
        total++; if (halted !== 1'b0) $display("FAIL halt_exec: got %b expected 0", halted); else passed++;
        step();
        instr = 16'h7000; instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({halted, instr_ready, pc} !== {1'b1, 1'b0, 8'd10})
                $display("FAIL halt_hold_%0d: got halted=%b ready=%b pc=%0d expected 1/0/10", i, halted, instr_ready, pc);
            else passed++;
            step();
        end
        instr_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; #1;
        total++; if ({halted, instr_ready, pc} !== {1'b0, 1'b1, 8'd0}) $display("FAIL halt_reset: got halted=%b ready=%b pc=%0d expected 0/1/0", halted, instr_ready, pc); else passed++;
    endtask

    task automatic test_reset_mid();
        step();
        issue(16'h7000); step(); // NOP -> pc=1
        issue(16'h0650); // ADD in EXEC
        total++; if (en !== 1'b1) $display("FAIL mid_exec_en: got %b expected 1", en); else passed++;
        rst = 1'b1; #1;
        total++; if ({write, en, instr_ready} !== 3'b000) $display("FAIL mid_rst_ctrl: got %b expected 000", {write, en, instr_ready}); else passed++;
        step();
        total++; if ({pc, write} !== {8'd0, 1'b0}) $display("FAIL mid_rst_pc: got pc=%0d write=%b expected 0/0", pc, write); else passed++;
        rst = 1'b0; #1;
        total++; if ({instr_ready, write, oe} !== 3'b100) $display("FAIL mid_rst_fetch: got %b expected 100", {instr_ready, write, oe}); else passed++;
        step();
        total++; if ({pc, write} !== {8'd0, 1'b0}) $display("FAIL mid_rst_after: got pc=%0d write=%b expected 0/0", pc, write); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        alu_r = 8'h00; z_flag = 1'b0; n_flag = 1'b0; o_flag = 1'b0;
        din = 8'h00; instr = 16'h0000; instr_valid = 1'b0; rst = 1'b1;
        test_reset();
        test_ldi_add_out();
        test_idle();
        test_branch();
        test_in_nop();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
